// File: rtl/updown_pkg.sv
// Shared types and default constants for the pushbutton front end.
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 16;
  localparam int DEF_REPEAT_PERIOD   = 4;

  // Button lanes: index into the per-button level/rise vectors.
  localparam int NUM_BTN = 2;
  localparam int BTN_UP  = 0;
  localparam int BTN_DN  = 1;

endpackage

// File: rtl/updown_ctrl_if.sv
// Raw buttons in, counter controls out.
interface updown_ctrl_if;
  logic btn_up;
  logic btn_dn;
  logic u;
  logic enable;
  logic held;

  modport master (output btn_up, output btn_dn, input u, input enable, input held);
  modport slave  (input btn_up, input btn_dn, output u, output enable, output held);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-sample counter for one raw button.
// level flips once the synchronised input has disagreed with it for
// DEBOUNCE_CYCLES+1 consecutive samples; rise pulses on the same edge
// as a 0->1 flip.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Synchronise, then count disagreeing samples until the level flips.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= ~level;
        rise  <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/updown_ctrl.sv
// Pushbutton front end for the 4-bit up/down counter: debounces the two
// buttons and turns presses into single-cycle count strobes with
// auto-repeat while a single button stays held.
module updown_ctrl
  import updown_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int TW              = 8
) (
  input logic         clk,
  input logic         clr,
  updown_ctrl_if.slave bus
);

  logic [NUM_BTN-1:0] btn_raw, lvl, rise;

  assign btn_raw[BTN_UP] = bus.btn_up;
  assign btn_raw[BTN_DN] = bus.btn_dn;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .clr   (clr),
      .btn   (btn_raw[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          u_q, u_n;
  logic          en_q, en_n;

  // u only changes alongside a strobe, so it also names the active button
  // while in DELAY/REPEAT.
  logic act_lvl, oth_lvl;
  assign act_lvl = u_q ? lvl[BTN_UP] : lvl[BTN_DN];
  assign oth_lvl = u_q ? lvl[BTN_DN] : lvl[BTN_UP];

  // State, timer and output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      timer <= '0;
      u_q   <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      u_q   <= u_n;
      en_q  <= en_n;
    end
  end

  // Next state: release / second button take priority over timer expiry.
  always_comb begin
    state_n = state;
    timer_n = timer;
    u_n     = u_q;
    en_n    = 1'b0;
    case (state)
      IDLE: begin
        if (lvl[BTN_UP] && lvl[BTN_DN]) begin
          state_n = LOCK;
        end else if (rise[BTN_UP]) begin
          en_n    = 1'b1;
          u_n     = 1'b1;
          timer_n = TW'(REPEAT_DELAY);
          state_n = DELAY;
        end else if (rise[BTN_DN]) begin
          en_n    = 1'b1;
          u_n     = 1'b0;
          timer_n = TW'(REPEAT_DELAY);
          state_n = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!act_lvl) begin
          state_n = IDLE;
        end else if (oth_lvl) begin
          state_n = LOCK;
        end else if (timer == TW'(1)) begin
          en_n    = 1'b1;
          timer_n = TW'(REPEAT_PERIOD);
          state_n = REPEAT;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      LOCK: begin
        if (!lvl[BTN_UP] && !lvl[BTN_DN]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.u      = u_q;
  assign bus.enable = en_q;
  assign bus.held   = (state == DELAY) || (state == REPEAT);

endmodule

// File: tb/tb_updown_ctrl.sv
// Bench for updown_ctrl: directed vector table, hand-written reset
// sequences, then random button activity against a timeline model.
module tb_updown_ctrl;

  localparam int DC = 4;
  localparam int RD = 16;
  localparam int RP = 4;
  localparam int LOGN = 8192;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  updown_ctrl_if bus();

  updown_ctrl #(.DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TW(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Downstream 4-bit counter, deliberately not tied to clr.
  logic [3:0] n = 4'd0;
  always_ff @(posedge clk) if (bus.enable) n <= bus.u ? n + 4'd1 : n - 4'd1;

  int n_cmp = 0;
  int n_bad = 0;
  bit prev_en;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Timeline view: every raw sample is logged by edge number; a level
  // changes when the last DC+1 synchronised samples (raw delayed two
  // edges) all disagree with it. Strobes are scheduled by absolute edge.
  bit raw_log [2][LOGN];
  int t_m;
  bit m_lvl [2];
  bit m_rise[2];
  int m_mode;   // 0 idle, 1 holding one button, 2 locked out
  bit m_dir;
  int m_next;
  bit m_en;

  function automatic void model_reset();
    t_m = 0; m_mode = 0; m_dir = 0; m_next = 0; m_en = 0;
    for (int b = 0; b < 2; b++) begin m_lvl[b] = 0; m_rise[b] = 0; end
  endfunction

  function automatic void model_step(input bit up, input bit dn);
    int act;
    bit diff;
    bit s;
    int idx;
    m_en = 0;
    case (m_mode)
      0: begin
        if (m_lvl[0] && m_lvl[1]) m_mode = 2;
        else if (m_rise[0]) begin m_en = 1; m_dir = 1; m_next = t_m + RD; m_mode = 1; end
        else if (m_rise[1]) begin m_en = 1; m_dir = 0; m_next = t_m + RD; m_mode = 1; end
      end
      1: begin
        act = m_dir ? 0 : 1;
        if (!m_lvl[act]) m_mode = 0;
        else if (m_lvl[1-act]) m_mode = 2;
        else if (t_m == m_next) begin m_en = 1; m_next = t_m + RP; end
      end
      default: if (!m_lvl[0] && !m_lvl[1]) m_mode = 0;
    endcase
    if (t_m < LOGN) begin raw_log[0][t_m] = up; raw_log[1][t_m] = dn; end
    for (int b = 0; b < 2; b++) begin
      diff = 1;
      for (int k = 0; k <= DC; k++) begin
        idx = t_m - k - 2;
        s = (idx < 0 || idx >= LOGN) ? 1'b0 : raw_log[b][idx];
        if (s == m_lvl[b]) diff = 0;
      end
      m_rise[b] = 0;
      if (diff) begin m_lvl[b] = !m_lvl[b]; m_rise[b] = m_lvl[b]; end
    end
    t_m++;
  endfunction

  // ---------------- drivers ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input bit up, input bit dn);
    bus.btn_up = up;
    bus.btn_dn = dn;
    @(posedge clk);
    model_step(up, dn);
    #1;
    chk("enable", int'(bus.enable), int'(m_en));
    chk("u", int'(bus.u), int'(m_dir));
    chk("held", int'(bus.held), int'(m_mode == 1));
    chk("enable_back_to_back", int'(prev_en & bus.enable), 0);
    prev_en = bus.enable;
    @(negedge clk);
  endtask

  // Called at a falling edge; clr spans one rising edge.
  task automatic do_reset();
    clr = 1'b1;
    #1;
    chk("rst_u", int'(bus.u), 0);
    chk("rst_enable", int'(bus.enable), 0);
    chk("rst_held", int'(bus.held), 0);
    model_reset();
    prev_en = 0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  typedef struct {
    int up_on, up_off, dn_on, dn_off;
    int cycles;
    int exp_pulses;
    int exp_first;
    bit exp_u;
    logic [3:0] exp_dn;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int pulses, first;
    logic [3:0] n0;
    bit up, dn;
    int rate;

    vecs[0] = '{0, 10, -1, -1, 40, 1,  7, 1'b1, 4'd1};   // single up press
    vecs[1] = '{-1, -1, 0, 3,  40, 0, -1, 1'b0, 4'd0};   // dn glitch
    vecs[2] = '{-1, -1, 0, 31, 60, 5,  7, 1'b0, 4'd11};  // dn auto-repeat
    vecs[3] = '{0, 20, 0, 40,  70, 0, -1, 1'b0, 4'd0};   // both together
    vecs[4] = '{0, 30, 15, 40, 70, 1,  7, 1'b1, 4'd1};   // dn joins held up
    vecs[5] = '{-1, -1, 0, 10, 40, 1,  7, 1'b0, 4'd15};  // single dn press

    clr = 1'b1;
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    prev_en = 0;
    model_reset();
    @(negedge clk);

    // Directed table.
    foreach (vecs[r]) begin
      do_reset();
      n0 = n;
      pulses = 0;
      first = -1;
      for (int t = 0; t < vecs[r].cycles; t++) begin
        up = (t >= vecs[r].up_on) && (t < vecs[r].up_off);
        dn = (t >= vecs[r].dn_on) && (t < vecs[r].dn_off);
        cyc(up, dn);
        if (bus.enable) begin
          pulses++;
          if (first < 0) first = t;
        end
      end
      chk($sformatf("vec%0d_pulses", r), pulses, vecs[r].exp_pulses);
      chk($sformatf("vec%0d_first", r), first, vecs[r].exp_first);
      chk($sformatf("vec%0d_u", r), int'(bus.u), int'(vecs[r].exp_u));
      chk($sformatf("vec%0d_n_delta", r), int'(4'(n - n0)), int'(vecs[r].exp_dn));
      chk($sformatf("vec%0d_held_end", r), int'(bus.held), 0);
    end

    // Reset while auto-repeating with up still held.
    do_reset();
    for (int t = 0; t < 28; t++) cyc(1'b1, 1'b0);
    chk("repeat_strobe_before_clr", int'(bus.enable), 1);
    chk("repeat_held_before_clr", int'(bus.held), 1);
    clr = 1'b1;
    #1;
    chk("midclr_enable", int'(bus.enable), 0);
    chk("midclr_held", int'(bus.held), 0);
    chk("midclr_u", int'(bus.u), 0);
    model_reset();
    prev_en = 0;
    @(negedge clk);
    clr = 1'b0;
    first = -1;
    for (int t = 0; t < 20; t++) begin
      cyc(1'b1, 1'b0);
      if (bus.enable && first < 0) begin
        first = t;
        chk("post_clr_u", int'(bus.u), 1);
      end
    end
    chk("post_clr_first", first, 7);

    // Random button activity with occasional resets.
    do_reset();
    up = 0;
    dn = 0;
    for (int i = 0; i < 3000; i++) begin
      rate = (i < 1000) ? 4 : (i < 2000) ? 12 : 40;
      if ($urandom_range(0, rate - 1) == 0) up = ~up;
      if ($urandom_range(0, rate - 1) == 0) dn = ~dn;
      if ($urandom_range(0, 699) == 0) do_reset();
      else cyc(up, dn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
